// File: rtl/interrupt_control.sv
// Interrupt enable/request/inhibit flags for the CPU state machine; flags update on the edge ending F1/F2/F3/E0.
// int_req is registered (1 clk); iot_skip is combinational during F3 only; state encoding F0..F3=0..3, D=4..7, E=8..11, H=12..15, EAE>=16.
module interrupt_control #(
  parameter int NDEV = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      state,
  input  logic [0:11]     instruction,
  input  logic            int_in_prog,
  input  logic            UF,
  input  logic [NDEV-1:0] dev_irq,
  input  logic [NDEV-1:0] dev_mask,
  output logic            int_req,
  output logic            int_ena,
  output logic            int_inh,
  output logic            uf_trap,
  output logic            iot_skip
);

  localparam logic [4:0] F1 = 5'd1;
  localparam logic [4:0] F2 = 5'd2;
  localparam logic [4:0] F3 = 5'd3;
  localparam logic [4:0] E0 = 5'd8;

  logic req_q, req_d;
  logic ena_q, ena_d;
  logic dly_q, dly_d;
  logic inh_q, inh_d;
  logic trap_q, trap_d;

  logic is_iot, iot_ok, jmp_jms, trap_cond;
  logic op_skon, op_ion, op_iof, op_srq, op_rtf, op_caf, op_cif, op_cint, op_sint;

  assign is_iot  = (instruction[0:2] == 3'b110);
  // In user mode the IOT becomes a trap, so none of its own effects may happen.
  assign iot_ok  = is_iot && !UF;
  assign jmp_jms = (instruction[0:1] == 2'b10);

  assign op_skon = iot_ok && (instruction == 12'o6000);
  assign op_ion  = iot_ok && (instruction == 12'o6001);
  assign op_iof  = iot_ok && (instruction == 12'o6002);
  assign op_srq  = iot_ok && (instruction == 12'o6003);
  assign op_rtf  = iot_ok && (instruction == 12'o6005);
  assign op_caf  = iot_ok && (instruction == 12'o6007);
  assign op_cif  = iot_ok && (instruction[0:5] == 6'o62) &&
                   ((instruction[9:11] == 3'o2) || (instruction[9:11] == 3'o3));
  assign op_cint = iot_ok && (instruction == 12'o6204);
  assign op_sint = iot_ok && (instruction == 12'o6254);

  assign trap_cond = UF && (is_iot ||
                     ((instruction[0:3] == 4'b1111) && !instruction[11] &&
                      (instruction[10] || instruction[9])));

  always_comb begin
    ena_d  = ena_q;
    dly_d  = dly_q;
    inh_d  = inh_q;
    trap_d = trap_q;
    req_d  = (|(dev_irq & dev_mask)) | trap_q;
    case (state)
      F1: begin
        if (dly_q) begin
          ena_d = 1'b1;
          dly_d = 1'b0;
        end
      end
      F2: begin
        if (jmp_jms)   inh_d  = 1'b0;
        if (trap_cond) trap_d = 1'b1;
      end
      F3: begin
        if (op_ion || op_rtf) dly_d = 1'b1;
        if (op_rtf || op_cif) inh_d = 1'b1;
        // Clears come last so they beat a pending enable delay.
        if (op_iof || op_skon) begin
          ena_d = 1'b0;
          dly_d = 1'b0;
        end
        if (op_caf) begin
          ena_d  = 1'b0;
          dly_d  = 1'b0;
          inh_d  = 1'b0;
          trap_d = 1'b0;
        end
        if (op_cint) trap_d = 1'b0;
      end
      E0: begin
        if (int_in_prog) begin
          ena_d = 1'b0;
          dly_d = 1'b0;
          inh_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q  <= 1'b0;
      ena_q  <= 1'b0;
      dly_q  <= 1'b0;
      inh_q  <= 1'b0;
      trap_q <= 1'b0;
    end else begin
      req_q  <= req_d;
      ena_q  <= ena_d;
      dly_q  <= dly_d;
      inh_q  <= inh_d;
      trap_q <= trap_d;
    end
  end

  assign int_req  = req_q;
  assign int_ena  = ena_q;
  assign int_inh  = inh_q;
  assign uf_trap  = trap_q;
  assign iot_skip = !reset && (state == F3) &&
                    ((op_skon && ena_q) || (op_srq && req_q) || (op_sint && trap_q));

endmodule
